// File: rtl/bitstream_decoder_if.sv
// ==== bitstream_decoder_if : start/abort/rail inputs and busy/valid/result outputs ====
// ==== rev 1.0 ====
`default_nettype none

interface bitstream_decoder_if #(
  parameter int LOG_LEN = 8
);
  logic               start;
  logic               abort;
  logic               x_p;
  logic               x_m;
  logic               busy;
  logic               valid;
  logic [LOG_LEN+1:0] y;

  modport master (
    output start, abort, x_p, x_m,
    input  busy, valid, y
  );

  modport slave (
    input  start, abort, x_p, x_m,
    output busy, valid, y
  );
endinterface

`default_nettype wire

// File: rtl/bitstream_decoder.sv
// ==== bitstream_decoder : counts x_p/x_m ones over a 2^LOG_LEN window, emits signed difference ====
// ==== rev 1.0 ====
`default_nettype none

module bitstream_decoder #(
  parameter int LOG_LEN = 8
) (
  input  wire logic          CLK,
  input  wire logic          nRST,
  bitstream_decoder_if.slave bus
);

  localparam logic [LOG_LEN:0] WIN_LEN = {1'b1, {LOG_LEN{1'b0}}};
  localparam logic [LOG_LEN:0] ONE     = {{LOG_LEN{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [LOG_LEN:0] cnt_p;
  logic [LOG_LEN:0] cnt_m;
  logic [LOG_LEN:0] smp;
  logic [LOG_LEN:0] smp_next;
  logic [LOG_LEN:0] inc_p;
  logic [LOG_LEN:0] inc_m;

  assign smp_next = smp + ONE;
  assign inc_p    = {{LOG_LEN{1'b0}}, bus.x_p};
  assign inc_m    = {{LOG_LEN{1'b0}}, bus.x_m};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      cnt_p     <= '0;
      cnt_m     <= '0;
      smp       <= '0;
      bus.busy  <= 1'b0;
      bus.valid <= 1'b0;
      bus.y     <= '0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt_p    <= '0;
            cnt_m    <= '0;
            smp      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt_p <= cnt_p + inc_p;
            cnt_m <= cnt_m + inc_m;
            smp   <= smp_next;
            if (smp_next == WIN_LEN) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          // abort wins over completion: drop the result, keep the old y
          if (!bus.abort) begin
            bus.y     <= {1'b0, cnt_p} - {1'b0, cnt_m};
            bus.valid <= 1'b1;
          end
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bitstream_decoder.sv
// ==== tb_bitstream_decoder : directed and random windows against a window-age reference model ====
// ==== rev 1.0 ====
`default_nettype none

module tb_bitstream_decoder;

  localparam int LOG_LEN = 4;
  localparam int N       = 1 << LOG_LEN;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  int vectors    = 0;
  int miscompares = 0;

  bitstream_decoder_if #(.LOG_LEN(LOG_LEN)) bus ();

  bitstream_decoder #(.LOG_LEN(LOG_LEN)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Reference: a window is open for N+1 edges after start; edges 1..N add x_p - x_m.
  bit         m_active = 0;
  int         m_age    = 0;
  int         m_sum    = 0;
  logic       exp_valid = 1'b0;
  logic [5:0] exp_y    = 6'd0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_active  = 0;
      exp_valid = 1'b0;
      exp_y     = 6'd0;
    end else begin
      exp_valid = 1'b0;
      if (!m_active) begin
        if (bus.start) begin
          m_active = 1;
          m_age    = 0;
          m_sum    = 0;
        end
      end else if (bus.abort) begin
        m_active = 0;
      end else begin
        m_age = m_age + 1;
        if (m_age <= N) begin
          m_sum = m_sum + int'(bus.x_p) - int'(bus.x_m);
        end else begin
          exp_y     = m_sum[5:0];
          exp_valid = 1'b1;
          m_active  = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    chk("busy",  {7'd0, bus.busy},  {7'd0, m_active});
    chk("valid", {7'd0, bus.valid}, {7'd0, exp_valid});
    chk("y",     {2'd0, bus.y},     {2'd0, exp_y});
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.start = 1'b0;
      bus.abort = 1'($urandom);
      bus.x_p   = 1'($urandom);
      bus.x_m   = 1'($urandom);
      @(negedge CLK);
    end
    bus.abort = 1'b0;
  endtask

  // Called at a negedge; start is sampled at the next edge T. Returns at the negedge after T+17.
  task automatic do_window(input logic [15:0] p, input logic [15:0] m, input int abort_at,
                           input bit pre_p, input logic [17:1] smask, output int busy_cnt);
    busy_cnt  = 0;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.x_p   = pre_p;
    bus.x_m   = 1'b0;
    @(negedge CLK);
    if (bus.busy) busy_cnt++;
    for (int k = 1; k <= 17; k++) begin
      bus.start = smask[k];
      bus.abort = (k == abort_at);
      bus.x_p   = (k <= 16) ? p[k-1] : 1'($urandom);
      bus.x_m   = (k <= 16) ? m[k-1] : 1'($urandom);
      @(negedge CLK);
      if (bus.busy) busy_cnt++;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc;
    int bc2;
    logic [15:0] rp;
    logic [15:0] rm;
    logic [17:1] sm;
    int ab;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.x_p   = 1'b0;
    bus.x_m   = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_busy",  {7'd0, bus.busy},  8'd0);
    chk("reset_valid", {7'd0, bus.valid}, 8'd0);
    chk("reset_y",     {2'd0, bus.y},     8'd0);
    nRST = 1'b1;
    idle(4);

    do_window(16'hFFFF, 16'h0000, 0, 1'b0, '0, bc);
    chk("full_pos_y",     {2'd0, bus.y},     8'h10);
    chk("full_pos_valid", {7'd0, bus.valid}, 8'd1);
    chk("full_pos_busy",  8'(bc),            8'd17);
    idle(2);

    do_window(16'h0000, 16'hFFFF, 0, 1'b0, '0, bc);
    chk("full_neg_y", {2'd0, bus.y}, 8'h30);
    idle(1);

    do_window(16'hFFFF, 16'hFFFF, 0, 1'b0, '0, bc);
    chk("cancel_y", {2'd0, bus.y}, 8'h00);
    idle(1);

    do_window(16'h0FFF, 16'h001F, 0, 1'b1, '0, bc);
    chk("mixed_y", {2'd0, bus.y}, 8'h07);
    idle(3);

    sm = '0;
    sm[3]  = 1'b1;
    sm[16] = 1'b1;
    do_window(16'h00FF, 16'h0003, 0, 1'b0, sm, bc);
    chk("ignored_start_y",    {2'd0, bus.y}, 8'h06);
    chk("ignored_start_busy", 8'(bc),        8'd17);
    do_window(16'h0001, 16'h0000, 0, 1'b0, '0, bc2);
    chk("b2b_y",     {2'd0, bus.y},     8'h01);
    chk("b2b_valid", {7'd0, bus.valid}, 8'd1);
    chk("b2b_busy",  8'(bc2),           8'd17);
    idle(2);

    do_window(16'hFFFF, 16'h0000, 8, 1'b0, '0, bc);
    chk("abort8_valid", {7'd0, bus.valid}, 8'd0);
    chk("abort8_y",     {2'd0, bus.y},     8'h01);
    chk("abort8_busy",  8'(bc),            8'd8);
    idle(2);

    do_window(16'hFFFF, 16'h0000, 17, 1'b0, '0, bc);
    chk("abort17_valid", {7'd0, bus.valid}, 8'd0);
    chk("abort17_y",     {2'd0, bus.y},     8'h01);
    idle(2);

    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    bus.x_p   = 1'b1;
    repeat (5) @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("async_rst_busy",  {7'd0, bus.busy},  8'd0);
    chk("async_rst_valid", {7'd0, bus.valid}, 8'd0);
    chk("async_rst_y",     {2'd0, bus.y},     8'd0);
    @(negedge CLK);
    nRST = 1'b1;
    idle(5);
    chk("post_rst_idle", {7'd0, bus.busy}, 8'd0);

    for (int w = 0; w < 40; w++) begin
      rp = 16'($urandom);
      rm = 16'($urandom) & 16'($urandom);
      sm = 17'($urandom & $urandom & $urandom);
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 17)) : 0;
      do_window(rp, rm, ab, 1'($urandom), sm, bc);
      idle(int'($urandom_range(0, 2)));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
